// File: rtl/dec_issue_queue_pkg.sv
// rtl/dec_issue_queue_pkg.sv - shared types, constants and fwd vector slicing for the decode issue queue
package dec_issue_queue_pkg;

    localparam int         DEC_PAYLOAD_W = 64;
    localparam logic [4:0] REG_ZERO      = 5'd0;

    typedef struct packed {
        logic [DEC_PAYLOAD_W-1:0] payload;
        logic [4:0]               src1;
        logic                     src1_en;
        logic [4:0]               src2;
        logic                     src2_en;
    } dec_entry_t;

    // Bit offset of producer idx inside a flattened fwd_dest / fwd_data vector.
    function automatic int fwd_lsb(input int idx, input int width);
        return idx * width;
    endfunction

endpackage

// File: rtl/dec_issue_queue_if.sv
// rtl/dec_issue_queue_if.sv - fetch-side push and execute-side issue handshakes of the decode issue queue
interface dec_issue_queue_if #(
    parameter int DATA_W    = 32,
    parameter int PAYLOAD_W = 64
);
    logic                 fs_to_ds_valid;
    logic [PAYLOAD_W-1:0] fs_payload;
    logic [4:0]           fs_src1;
    logic [4:0]           fs_src2;
    logic                 fs_src1_en;
    logic                 fs_src2_en;
    logic                 ds_allowin;

    logic                 es_allowin;
    logic                 ds_to_es_valid;
    logic [PAYLOAD_W-1:0] ds_payload;
    logic [DATA_W-1:0]    ds_src1_value;
    logic [DATA_W-1:0]    ds_src2_value;

    modport master (
        output fs_to_ds_valid, fs_payload, fs_src1, fs_src2, fs_src1_en, fs_src2_en, es_allowin,
        input  ds_allowin, ds_to_es_valid, ds_payload, ds_src1_value, ds_src2_value
    );

    modport slave (
        input  fs_to_ds_valid, fs_payload, fs_src1, fs_src2, fs_src1_en, fs_src2_en, es_allowin,
        output ds_allowin, ds_to_es_valid, ds_payload, ds_src1_value, ds_src2_value
    );

endinterface

// File: rtl/dec_operand_sel.sv
// rtl/dec_operand_sel.sv - per-source producer match, interlock and operand select (DEC_BYPASS_EN enables forwarding)
module dec_operand_sel
    import dec_issue_queue_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int N_FWD  = 3
) (
    input  logic [4:0]              src,
    input  logic                    src_en,
    input  logic [N_FWD-1:0]        fwd_we,
    input  logic [5*N_FWD-1:0]      fwd_dest,
    input  logic [DATA_W*N_FWD-1:0] fwd_data,
    input  logic [N_FWD-1:0]        fwd_pending,
    input  logic [DATA_W-1:0]       rf_rdata,
    output logic                    blocked,
    output logic [DATA_W-1:0]       value
);

    logic              used;
    logic              hit;
    logic              hit_pending;
    logic [DATA_W-1:0] hit_data;

    assign used = src_en && (src != REG_ZERO);

    // Scan oldest to youngest so the lowest matching index is the one left standing.
    always_comb begin
        hit         = 1'b0;
        hit_pending = 1'b0;
        hit_data    = '0;
        for (int i = N_FWD - 1; i >= 0; i--) begin
            if (fwd_we[i] && (fwd_dest[fwd_lsb(i, 5) +: 5] == src)) begin
                hit         = 1'b1;
                hit_pending = fwd_pending[i];
                hit_data    = fwd_data[fwd_lsb(i, DATA_W) +: DATA_W];
            end
        end
    end

`ifdef DEC_BYPASS_EN
    assign blocked = used && hit && hit_pending;
    assign value   = !used ? '0 : (hit ? hit_data : rf_rdata);
`else
    logic unused_fwd;
    assign unused_fwd = ^{hit_pending, hit_data};
    assign blocked    = used && hit;
    assign value      = used ? rf_rdata : '0;
`endif

endmodule

// File: rtl/dec_issue_queue.sv
// rtl/dec_issue_queue.sv - in-order decode issue queue with head operand resolve, interlock and flush (DEC_BYPASS_EN)
module dec_issue_queue
    import dec_issue_queue_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int PAYLOAD_W = 64,
    parameter int DEPTH     = 4,
    parameter int N_FWD     = 3
) (
    input  logic                         clk,
    input  logic                         reset,
    dec_issue_queue_if.slave             bus,
    output logic [4:0]                   rf_raddr1,
    output logic [4:0]                   rf_raddr2,
    input  logic [DATA_W-1:0]            rf_rdata1,
    input  logic [DATA_W-1:0]            rf_rdata2,
    input  logic [N_FWD-1:0]             fwd_we,
    input  logic [5*N_FWD-1:0]           fwd_dest,
    input  logic [DATA_W*N_FWD-1:0]      fwd_data,
    input  logic [N_FWD-1:0]             fwd_pending,
    input  logic                         flush,
    output logic [$clog2(DEPTH+1)-1:0]   ds_count,
    output logic [31:0]                  stall_cnt
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    if (PAYLOAD_W != DEC_PAYLOAD_W) begin : g_payload_w_check
        $error("PAYLOAD_W must equal DEC_PAYLOAD_W");
    end

    dec_entry_t       mem [DEPTH];
    dec_entry_t       head;
    dec_entry_t       in_entry;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             blk1;
    logic             blk2;
    logic             head_valid;
    logic             allowin;
    logic             issue_valid;
    logic             push;
    logic             pop;

    assign head     = mem[rd_ptr];
    assign in_entry = '{payload: bus.fs_payload,
                        src1:    bus.fs_src1, src1_en: bus.fs_src1_en,
                        src2:    bus.fs_src2, src2_en: bus.fs_src2_en};

    assign head_valid  = (count != '0);
    assign allowin     = (count < CNT_W'(DEPTH));
    assign issue_valid = head_valid && !blk1 && !blk2;
    // A flushing cycle drops the incoming push but still honours the pop execute took.
    assign push        = bus.fs_to_ds_valid && allowin && !flush;
    assign pop         = issue_valid && bus.es_allowin;

    assign bus.ds_allowin     = allowin;
    assign bus.ds_to_es_valid = issue_valid;
    assign bus.ds_payload     = head.payload;
    assign rf_raddr1          = head.src1;
    assign rf_raddr2          = head.src2;
    assign ds_count           = count;

    dec_operand_sel #(.DATA_W(DATA_W), .N_FWD(N_FWD)) u_src1 (
        .src(head.src1), .src_en(head.src1_en),
        .fwd_we(fwd_we), .fwd_dest(fwd_dest), .fwd_data(fwd_data), .fwd_pending(fwd_pending),
        .rf_rdata(rf_rdata1), .blocked(blk1), .value(bus.ds_src1_value)
    );

    dec_operand_sel #(.DATA_W(DATA_W), .N_FWD(N_FWD)) u_src2 (
        .src(head.src2), .src_en(head.src2_en),
        .fwd_we(fwd_we), .fwd_dest(fwd_dest), .fwd_data(fwd_data), .fwd_pending(fwd_pending),
        .rf_rdata(rf_rdata2), .blocked(blk2), .value(bus.ds_src2_value)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            stall_cnt <= '0;
        end else begin
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + PTR_W'(1);
                if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
                if (push && !pop)      count <= count + CNT_W'(1);
                else if (pop && !push) count <= count - CNT_W'(1);
            end
            if (head_valid && (blk1 || blk2) && (stall_cnt != 32'hFFFF_FFFF))
                stall_cnt <= stall_cnt + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !reset) mem[wr_ptr] <= in_entry;
    end

endmodule

// File: doc/dec_issue_queue.md
# dec_issue_queue

Parametrised decode/issue stage: a DEPTH-entry in-order instruction queue between fetch and execute. It resolves source operands for the head entry from the register file and N_FWD bypass sources, and interlocks while any matching producer is pending (load in EXE, divide in flight). It replaces the single-register decode latch with a buffered issue point. It also supports redirect flush and keeps a hazard-stall cycle counter.

## Interface
- DATA_W, 32, register data width
- PAYLOAD_W, 64, opaque per-instruction bus ({inst, pc} plus decoded controls), passed through unchanged
- DEPTH, 4, queue entries; power of two, ≥2
- N_FWD, 3, bypass sources; index 0 is the youngest producer (EXE), higher index is older

Ports (clock and reset first):
- clk  in  1  sole clock
- reset  in  1  synchronous, active-high
- fs_to_ds_valid  in  1  fetch offers an entry
- fs_payload  in  PAYLOAD_W  entry payload
- fs_src1, fs_src2  in  5 each  source register numbers
- fs_src1_en, fs_src2_en  in  1 each  source is actually read
- ds_allowin  out  1  queue can accept this cycle
- rf_raddr1, rf_raddr2  out  5 each  regfile read addresses, driven from head entry
- rf_rdata1, rf_rdata2  in  DATA_W each  combinational regfile data
- fwd_we  in  N_FWD  producer writes a GPR
- fwd_dest  in  5·N_FWD  producer destination; source i occupies bits [5i+4:5i]
- fwd_data  in  DATA_W·N_FWD  producer result
- fwd_pending  in  N_FWD  result not yet valid
- es_allowin  in  1  execute accepts
- ds_to_es_valid  out  1  head issuable
- ds_payload  out  PAYLOAD_W  head payload
- ds_src1_value, ds_src2_value  out  DATA_W each  resolved operands
- flush  in  1  redirect; discard all queued entries
- ds_count  out  $clog2(DEPTH+1)  occupancy
- stall_cnt  out  32  cycles the head was blocked by a hazard

## Operation
- Push: fs_to_ds_valid & ds_allowin writes the entry at the tail.
- ds_allowin = (ds_count < DEPTH). There is no pass-through when full.
- Pop: ds_to_es_valid & es_allowin removes the head.
- Head hazard. For each enabled source with a nonzero register number, match against source i when fwd_we[i] and fwd_dest[i] equal that register number. The lowest matching index wins. A source is blocked if the winning match has fwd_pending set.
- ds_to_es_valid = (ds_count ≠ 0) & no blocked source.
- Operand value, per source:
  - 0 when the register is r0 or the source is disabled;
  - otherwise fwd_data of the winning match;
  - otherwise rf_rdata.
- Flush: pointers and count go to 0. A push in the same cycle is dropped. A pop in the same cycle still completes, because execute captured it.
- Push and pop in the same cycle: the count is unchanged. When full, a push is refused even if a pop happens that cycle.
- Pointers are log2(DEPTH) bits wide and wrap naturally. Occupancy is tracked by the count, not by pointer comparison.
- stall_cnt increments on every cycle with a valid head that is blocked, saturating at 2^32−1. flush does not clear it.

## Timing
- Reset values: ds_count=0, ds_to_es_valid=0, ds_allowin=1, stall_cnt=0, pointers=0. Payload storage is not reset. Pushes during the reset cycle are ignored.
- Push→issue latency is 1 cycle: an entry pushed in cycle t can be presented in cycle t+1.
- All hazard and operand logic is combinational on the head entry, the fwd_* inputs and rf_rdata. Only the queue, pointers, count and stall_cnt are registered.
- A blocked head holds every output stable until the hazard clears.
- Reset asserted mid-operation discards contents exactly as flush does and also clears stall_cnt.

## Configuration
- DEC_BYPASS_EN defined: forwarding as above; only pending matches block.
- DEC_BYPASS_EN undefined:
  - any match blocks, pending or not;
  - operands always come from rf_rdata;
  - fwd_data is unused.

## Structure
- Shared package holds:
  - a typedef for the queue entry {payload, src1, src1_en, src2, src2_en};
  - a REG_ZERO constant (5'd0);
  - the slicing helper for the fwd_dest / fwd_data vectors.
- One sub-module, dec_operand_sel, instantiated twice (src1, src2). It performs the per-source priority match across N_FWD and outputs {blocked, value}.

## Test plan
- Fill: DEPTH=4 with es_allowin=0. Push 5 entries → ds_allowin=0 after 4 pushes, ds_count=4, 5th entry not stored. Raise es_allowin → entries issue in order, one per cycle.
- Priority bypass: head src1=r5. fwd_we=3'b110, dest[1]=dest[2]=5 with data 0x11 / 0x22 → ds_src1_value=0x11. Add dest[0]=5, data 0x33 → 0x33.
- Load-use: fwd_pending[0]=1, dest[0]=7, head src2=r7 → ds_to_es_valid=0 for 3 cycles and stall_cnt=3. Drop pending → issues with fwd_data[0].
- r0 / disabled: src1=r0 with dest[0]=0, pending=1 → no stall, value 0.
- Flush: ds_count=3 with a simultaneous push and pop → next cycle ds_count=0, ds_to_es_valid=0, popped entry delivered once.
- Macro off: match with pending=0 → ds_to_es_valid=0 until fwd_we drops, then value equals rf_rdata.
